// File: rtl/io_responder.sv
// io_responder: side-bus peripheral with two output latches, two synchronized
// input ports and a small transmit FIFO drained over a valid/ready stream.
module io_responder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] io_data,
  input  logic [3:0] io_addr,
  input  logic       io_oe,
  input  logic       io_we,
  output logic [7:0] port_a_out,
  output logic [7:0] port_b_out,
  input  logic [7:0] port_a_in,
  input  logic [7:0] port_b_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [3:0] ADDR_OUT_A  = 4'h0;
  localparam logic [3:0] ADDR_OUT_B  = 4'h1;
  localparam logic [3:0] ADDR_IN_A   = 4'h2;
  localparam logic [3:0] ADDR_IN_B   = 4'h3;
  localparam logic [3:0] ADDR_TXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h5;
  localparam logic [3:0] ADDR_CTRL   = 4'h6;

  logic [7:0]    out_a_q, out_a_d, out_b_q, out_b_d;
  logic [7:0]    sync_a_q [SYNC_STAGES];
  logic [7:0]    sync_a_d [SYNC_STAGES];
  logic [7:0]    sync_b_q [SYNC_STAGES];
  logic [7:0]    sync_b_d [SYNC_STAGES];
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic       push_req, push_ok, pop, flush, ovf_clr, full, empty;
  logic [2:0] count3;
  logic [7:0] rd_data;

  // Bus decode: a write strobe always wins over a read strobe.
  assign push_req = io_we && (io_addr == ADDR_TXDATA);
  assign flush    = io_we && (io_addr == ADDR_CTRL) && io_data[1];
  assign ovf_clr  = io_we && (io_addr == ADDR_CTRL) && io_data[0];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok  = push_req && !flush && (!full || pop);
  assign count3   = 3'(count_q);

  assign tx_data    = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign port_a_out = out_a_q;
  assign port_b_out = out_b_q;

  // Output latches capture the bus on a write to their address.
  always_comb begin
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (io_we && io_addr == ADDR_OUT_A) out_a_d = io_data;
    if (io_we && io_addr == ADDR_OUT_B) out_b_d = io_data;
  end

  // Input synchronizer chains: stage 0 samples the pin, later stages shift.
  always_comb begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sync_a_d[i] = (i == 0) ? port_a_in : sync_a_q[(i == 0) ? 0 : i - 1];
      sync_b_d[i] = (i == 0) ? port_b_in : sync_b_q[(i == 0) ? 0 : i - 1];
    end
  end

  // FIFO next state: flush beats push and pop; overflow is sticky until cleared.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = io_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (push_req && full && !pop) ovf_d = 1'b1;
    end
  end

  // Read mux: STATUS reflects state as of the last edge.
  always_comb begin
    rd_data = 8'h00;
    case (io_addr)
      ADDR_OUT_A:  rd_data = out_a_q;
      ADDR_OUT_B:  rd_data = out_b_q;
      ADDR_IN_A:   rd_data = sync_a_q[SYNC_STAGES-1];
      ADDR_IN_B:   rd_data = sync_b_q[SYNC_STAGES-1];
      ADDR_STATUS: rd_data = {1'b0, count3, 1'b0, ovf_q, full, empty};
      default:     rd_data = 8'h00;
    endcase
  end

  // Drive the shared bus only for a pure read outside reset.
  assign io_data = (io_oe && !io_we && reset) ? rd_data : 8'bz;

  // All state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_a_q  <= 8'h00;
      out_b_q  <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_a_q[i] <= 8'h00;
        sync_b_q[i] <= 8'h00;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_a_q[i] <= sync_a_d[i];
        sync_b_q[i] <= sync_b_d[i];
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
